sipo_rx: RTL

SIPO_RX -- requirements
Module: sipo_rx

---
 rtl/sipo_rx.sv | 90 +++++++++
 1 files changed

// File: rtl/sipo_rx.sv
// Serial-to-parallel receiver: assembles LEN-bit LSB-first words framed by isync,
// publishing each completed word on o with a one-cycle osync pulse.
module sipo_rx #(
  parameter int LEN = 5
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           s,
  input  logic           isync,
  output logic [LEN-1:0] o,
  output logic           osync,
  output logic           busy,
  output logic           err
);

  localparam int CW = $clog2(LEN);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  logic [0:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [LEN-1:0] asm_q, asm_d;
  logic [LEN-1:0] o_q, o_d;
  logic           osync_q, osync_d;
  logic           err_q, err_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    o_d     = o_q;
    osync_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (isync) begin
          asm_d[0] = s;
          cnt_d    = CW'(1);
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (isync) begin
          // Premature frame marker: drop the partial word and restart on this bit.
          err_d    = 1'b1;
          asm_d[0] = s;
          cnt_d    = CW'(1);
        end else if (cnt_q == LAST) begin
          asm_d[LEN-1] = s;
          o_d          = {s, asm_q[LEN-2:0]};
          osync_d      = 1'b1;
          cnt_d        = '0;
          state_d      = IDLE;
        end else begin
          asm_d[cnt_q] = s;
          cnt_d        = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      asm_q   <= '0;
      o_q     <= '0;
      osync_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      o_q     <= o_d;
      osync_q <= osync_d;
      err_q   <= err_d;
    end
  end

  assign o     = o_q;
  assign osync = osync_q;
  assign err   = err_q;
  assign busy  = (state_q == SHIFT);

endmodule
